// File: rtl/conv_4_sdiv_24s_8s_seq.sv
// Sequential signed divider: 24-bit dividend by 8-bit divisor, restoring algorithm, one bit
// per cycle, saturating 16-bit quotient with truncation toward zero.
module conv_4_sdiv_24s_8s_seq #(
    parameter int unsigned ID         = 32'd1,
    parameter int unsigned din0_WIDTH = 32'd24,
    parameter int unsigned din1_WIDTH = 32'd8,
    parameter int unsigned dout_WIDTH = 32'd16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ap_idle,
    output logic                  ap_ready,
    output logic                  ap_done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [7:0]            rem,
    output logic                  ovf,
    output logic                  dz
);

    // ID is an instance tag only; this empty block merely references it.
    if (ID == 32'hffff_ffff) begin : g_id_tag
    end

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StFix  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]  state_q, state_d;
    // Dividend magnitude shifts out MSB-first while quotient bits shift in at the LSB.
    logic [23:0] quo_q, quo_d;
    logic [8:0]  dvs_q, dvs_d;
    logic [8:0]  prem_q, prem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        s0_q, s0_d, s1_q, s1_d;
    logic [15:0] dout_q, dout_d;
    logic [7:0]  rem_q, rem_d;
    logic        ovf_q, ovf_d, dz_q, dz_d;

    logic [8:0]  din1_ext;
    logic [9:0]  shifted, diff;
    logic [23:0] quo_neg;
    logic [7:0]  rem_neg;

    assign din1_ext = {din1[7], din1};
    assign shifted  = {prem_q, quo_q[23]};
    assign diff     = shifted - {1'b0, dvs_q};
    assign quo_neg  = ~quo_q + 24'd1;
    assign rem_neg  = ~prem_q[7:0] + 8'd1;

    always_comb begin
        state_d = state_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        dout_d  = dout_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        unique case (state_q)
            StIdle: begin
                if (ap_start) begin
                    quo_d   = din0[23] ? (~din0 + 24'd1) : din0;
                    dvs_d   = din1_ext[8] ? (~din1_ext + 9'd1) : din1_ext;
                    s0_d    = din0[23];
                    s1_d    = din1[7];
                    prem_d  = 9'd0;
                    cnt_d   = 5'd23;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (!diff[9]) begin
                    prem_d = diff[8:0];
                    quo_d  = {quo_q[22:0], 1'b1};
                end else begin
                    prem_d = shifted[8:0];
                    quo_d  = {quo_q[22:0], 1'b0};
                end
                if (cnt_q == 5'd0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            StFix: begin
                if (dvs_q == 9'd0) begin
                    dout_d = s0_q ? 16'h8000 : 16'h7fff;
                    rem_d  = 8'd0;
                    ovf_d  = 1'b1;
                    dz_d   = 1'b1;
                end else begin
                    dz_d  = 1'b0;
                    rem_d = s0_q ? rem_neg : prem_q[7:0];
                    if (s0_q ^ s1_q) begin
                        ovf_d  = (quo_q > 24'd32768);
                        dout_d = ovf_d ? 16'h8000 : quo_neg[15:0];
                    end else begin
                        ovf_d  = (quo_q > 24'd32767);
                        dout_d = ovf_d ? 16'h7fff : quo_q[15:0];
                    end
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q <= StIdle;
            quo_q   <= 24'd0;
            dvs_q   <= 9'd0;
            prem_q  <= 9'd0;
            cnt_q   <= 5'd0;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            dout_q  <= 16'd0;
            rem_q   <= 8'd0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    assign ap_idle  = (state_q == StIdle);
    assign ap_ready = ap_idle & ap_start;
    assign ap_done  = (state_q == StDone);
    assign dout     = dout_q;
    assign rem      = rem_q;
    assign ovf      = ovf_q;
    assign dz       = dz_q;

endmodule

// File: tb/tb_conv_4_sdiv_24s_8s_seq.sv
// Directed bench for conv_4_sdiv_24s_8s_seq: latency, sign handling, saturation,
// divide-by-zero, back-to-back requests and reset abort.
module tb_conv_4_sdiv_24s_8s_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        ap_start = 1'b0;
    logic [23:0] din0 = 24'd0;
    logic [7:0]  din1 = 8'd0;
    logic        ap_idle, ap_ready, ap_done;
    logic [15:0] dout;
    logic [7:0]  rem;
    logic        ovf, dz;

    int errors = 0;
    int checks = 0;

    conv_4_sdiv_24s_8s_seq dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .ap_start (ap_start),
        .din0     (din0),
        .din1     (din1),
        .ap_idle  (ap_idle),
        .ap_ready (ap_ready),
        .ap_done  (ap_done),
        .dout     (dout),
        .rem      (rem),
        .ovf      (ovf),
        .dz       (dz)
    );

    always #5 ap_clk = ~ap_clk;

    // Starts one division and returns the number of edges from acceptance to ap_done.
    task automatic run_div(input logic [23:0] a, input logic [7:0] b, output int lat);
        int g = 0;
        while (ap_idle !== 1'b1 && g < 100) begin
            @(negedge ap_clk);
            g++;
        end
        @(negedge ap_clk);
        din0 = a;
        din1 = b;
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        din0 = ~a;
        din1 = 8'h5a;
        lat = 1;
        while (ap_done !== 1'b1 && lat < 60) begin
            @(negedge ap_clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        ap_start = 1'b1;
        din0 = 24'd1000;
        din1 = 8'd7;
        repeat (3) @(negedge ap_clk);
        checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", ap_idle); end
        checks++; if (ap_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", ap_done); end
        checks++; if (dout !== 16'd0) begin errors++; $display("FAIL reset_dout got=%h exp=0", dout); end
        checks++; if (rem !== 8'd0) begin errors++; $display("FAIL reset_rem got=%h exp=0", rem); end
        checks++; if (ovf !== 1'b0 || dz !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", ovf, dz); end
        ap_start = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
    endtask

    task automatic test_basic();
        int lat;
        run_div(24'd1000, 8'd7, lat);
        checks++; if (lat !== 26) begin errors++; $display("FAIL basic_latency got=%0d exp=26", lat); end
        checks++; if (dout !== 16'd142) begin errors++; $display("FAIL basic_dout got=%0d exp=142", $signed(dout)); end
        checks++; if (rem !== 8'd6) begin errors++; $display("FAIL basic_rem got=%0d exp=6", $signed(rem)); end
        checks++; if (ovf !== 1'b0 || dz !== 1'b0) begin errors++; $display("FAIL basic_flags got=%b%b exp=00", ovf, dz); end
        @(negedge ap_clk);
        checks++; if (ap_done !== 1'b0 || ap_idle !== 1'b1) begin
            errors++; $display("FAIL basic_done_pulse got done=%b idle=%b exp done=0 idle=1", ap_done, ap_idle);
        end
        checks++; if (dout !== 16'd142 || rem !== 8'd6) begin errors++; $display("FAIL basic_hold got=%0d/%0d exp=142/6", $signed(dout), $signed(rem)); end
    endtask

    task automatic test_vectors();
        int va [15] = '{1000, -1000, 1000, -1000, 8388607, -8388608, -8388608, -5, 5, 0,
                        -32768, 32767, 32768, 1000, -1};
        int vb [15] = '{7, 7, -7, -7, 1, -1, 127, 0, 0, 0, 1, 1, 1, -128, -128};
        int eq [15] = '{142, -142, -142, 142, 32767, 32767, -32768, -32768, 32767, 32767,
                        -32768, 32767, 32767, -7, 0};
        int er [15] = '{6, -6, 6, -6, 0, 0, -4, 0, 0, 0, 0, 0, 0, 104, -1};
        int eo [15] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 1, 0, 0};
        int ez [15] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
        int lat;
        logic [15:0] xq;
        logic [7:0]  xr;
        for (int i = 0; i < 15; i++) begin
            xq = 16'(eq[i]);
            xr = 8'(er[i]);
            run_div(24'(va[i]), 8'(vb[i]), lat);
            checks++; if (lat !== 26) begin errors++; $display("FAIL vec%0d_latency got=%0d exp=26", i, lat); end
            checks++; if (dout !== xq) begin errors++; $display("FAIL vec%0d_dout got=%0d exp=%0d", i, $signed(dout), eq[i]); end
            checks++; if (rem !== xr) begin errors++; $display("FAIL vec%0d_rem got=%0d exp=%0d", i, $signed(rem), er[i]); end
            checks++; if (ovf !== eo[i][0] || dz !== ez[i][0]) begin
                errors++; $display("FAIL vec%0d_flags got ovf=%b dz=%b exp ovf=%0d dz=%0d", i, ovf, dz, eo[i], ez[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int rdy_at [3];
        int nrdy = 0;
        int ndone = 0;
        int cyc = 0;
        int g = 0;
        while (ap_idle !== 1'b1 && g < 100) begin @(negedge ap_clk); g++; end
        @(negedge ap_clk);
        din0 = 24'd1000;
        din1 = 8'd7;
        ap_start = 1'b1;
        while ((nrdy < 3 || ndone < 2) && cyc < 200) begin
            if (ap_ready === 1'b1 && nrdy < 3) begin rdy_at[nrdy] = cyc; nrdy++; end
            if (ap_done === 1'b1) begin
                if (ndone == 0) begin
                    checks++; if (dout !== 16'd142 || rem !== 8'd6) begin
                        errors++; $display("FAIL b2b_first got=%0d/%0d exp=142/6", $signed(dout), $signed(rem));
                    end
                end else if (ndone == 1) begin
                    checks++; if (dout !== 16'd25 || rem !== 8'd2) begin
                        errors++; $display("FAIL b2b_second got=%0d/%0d exp=25/2", $signed(dout), $signed(rem));
                    end
                end
                ndone++;
            end
            if (cyc == 12) begin din0 = 24'd77; din1 = 8'd3; end
            @(negedge ap_clk);
            cyc++;
        end
        ap_start = 1'b0;
        checks++; if (nrdy !== 3 || ndone < 2) begin
            errors++; $display("FAIL b2b_count got ready=%0d done=%0d exp ready=3 done>=2", nrdy, ndone);
        end else begin
            checks++; if (rdy_at[1] - rdy_at[0] !== 27) begin
                errors++; $display("FAIL b2b_period1 got=%0d exp=27", rdy_at[1] - rdy_at[0]);
            end
            checks++; if (rdy_at[2] - rdy_at[1] !== 27) begin
                errors++; $display("FAIL b2b_period2 got=%0d exp=27", rdy_at[2] - rdy_at[1]);
            end
        end
        g = 0;
        while (ap_idle !== 1'b1 && g < 100) begin @(negedge ap_clk); g++; end
    endtask

    task automatic test_reset_abort();
        int lat;
        logic seen = 1'b0;
        @(negedge ap_clk);
        din0 = 24'd1000;
        din1 = 8'd7;
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        repeat (10) @(negedge ap_clk);
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL abort_idle got=%b exp=1", ap_idle); end
        checks++; if (dout !== 16'd0 || rem !== 8'd0) begin errors++; $display("FAIL abort_outputs got=%h/%h exp=0/0", dout, rem); end
        checks++; if (ovf !== 1'b0 || dz !== 1'b0) begin errors++; $display("FAIL abort_flags got=%b%b exp=00", ovf, dz); end
        for (int i = 0; i < 40; i++) begin
            if (ap_done === 1'b1) seen = 1'b1;
            @(negedge ap_clk);
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done got=%b exp=0", seen); end
        run_div(24'd1000, 8'd7, lat);
        checks++; if (lat !== 26) begin errors++; $display("FAIL abort_rerun_latency got=%0d exp=26", lat); end
        checks++; if (dout !== 16'd142 || rem !== 8'd6) begin
            errors++; $display("FAIL abort_rerun got=%0d/%0d exp=142/6", $signed(dout), $signed(rem));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
